// File: rtl/lsu_req_ctrl.sv
// Load/store request controller between EXU and the data SRAM port.
// One op in flight: decode on accept, drive an aligned SRAM request, extract load data, return to WBU.
module lsu_req_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic [1:0]  out_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_MIS = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;
   localparam logic [1:0] ERR_ILL = 2'b11;

   state_t      state, state_nxt;
   logic        ld_q, st_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q;
   logic [4:0]  rd_q;
   logic [15:0] cnt_q;
   logic [31:0] data_q;
   logic [1:0]  err_q;

   // incoming op decode
   logic       in_mem, in_legal, in_misal;
   logic [1:0] in_err;

   always_comb begin
      in_mem   = in_is_load | in_is_store;
      in_legal = 1'b0;
      if (in_is_load && !in_is_store)
         in_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                    (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
      else if (in_is_store && !in_is_load)
         in_legal = !in_funct3[2] && (in_funct3[1:0] != 2'b11);
      in_misal = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
      if (!in_mem)        in_err = ERR_OK;
      else if (!in_legal) in_err = ERR_ILL;
      else if (in_misal)  in_err = ERR_MIS;
      else                in_err = ERR_OK;
   end

   logic [1:0]  off;
   logic [31:0] sh, ld_data;
   logic [16:0] cnt_inc;
   logic        tmo;

   assign off     = addr_q[1:0];
   assign sh      = mem_rdata >> {off, 3'b000};
   assign cnt_inc = {1'b0, cnt_q} + 17'd1;
   // the cycle whose increment would make the count reach TIMEOUT is the last WAIT cycle
   assign tmo     = cnt_inc >= 17'(TIMEOUT);

   always_comb begin
      unique case (f3_q)
         3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ld_data = {24'b0, sh[7:0]};
         3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ld_data = {16'b0, sh[15:0]};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      mem_wmask = 4'b0000;
      mem_wdata = 32'b0;
      if (st_q) begin
         unique case (f3_q[1:0])
            2'b00: begin
               mem_wmask = 4'b0001 << off;
               mem_wdata = {24'b0, wdata_q[7:0]} << {off, 3'b000};
            end
            2'b01: begin
               mem_wmask = 4'b0011 << off;
               mem_wdata = {16'b0, wdata_q[15:0]} << {off, 3'b000};
            end
            default: begin
               mem_wmask = 4'b1111;
               mem_wdata = wdata_q;
            end
         endcase
      end
   end

   assign mem_addr = {addr_q[31:2], 2'b00};
   assign mem_wen  = st_q;
   assign out_data = data_q;
   assign out_rd   = rd_q;
   assign out_err  = err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = (in_mem && in_err == ERR_OK) ? REQ : RESP;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid || tmo) state_nxt = RESP;
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         rd_q    <= 5'b0;
         cnt_q   <= 16'b0;
         data_q  <= 32'b0;
         err_q   <= ERR_OK;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               ld_q    <= in_is_load;
               st_q    <= in_is_store;
               f3_q    <= in_funct3;
               addr_q  <= in_addr;
               wdata_q <= in_wdata;
               rd_q    <= in_rd;
               cnt_q   <= 16'b0;
               err_q   <= in_err;
               data_q  <= in_mem ? 32'b0 : in_addr;
            end
            REQ: if (mem_req_ready) cnt_q <= 16'b0;
            WAIT: begin
               cnt_q <= cnt_inc[15:0];
               if (mem_resp_valid) begin
                  data_q <= ld_q ? ld_data : 32'b0;
                  err_q  <= ERR_OK;
               end else if (tmo) begin
                  data_q <= 32'b0;
                  err_q  <= ERR_TMO;
               end
            end
            RESP: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Randomized bench for lsu_req_ctrl with an op-level reference model and directed corner cases.
module tb_lsu_req_ctrl;
   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_is_load, in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic [1:0]  out_err;

   int n_chk = 0;
   int n_err = 0;

   lsu_req_ctrl #(.TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_err(out_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_req_valid"}, mem_req_valid, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_wen"}, mem_wen, 0);
      chk({tag, "_wmask"}, mem_wmask, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_rd"}, out_rd, 0);
      chk({tag, "_out_err"}, out_err, 0);
   endtask

   // d = WAIT cycle index carrying the response; d >= TMO means it never comes in time
   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int stall, input int d, input int h);
      logic [1:0]  e_err;
      logic [31:0] e_data, e_wd, b, v;
      logic [3:0]  e_mask;
      bit          is_mem;
      int          off;
      off = int'(addr % 4);
      e_data = 0; e_wd = 0; e_mask = 0; is_mem = 0; e_err = 0;
      if (!ld && !st) e_data = addr;
      else if ((ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
               (st && !(f3 inside {3'd0, 3'd1, 3'd2}))) e_err = 3;
      else if ((f3[1:0] == 2'd1 && off % 2 != 0) || (f3[1:0] == 2'd2 && off != 0)) e_err = 1;
      else is_mem = 1;
      if (is_mem && st) begin
         case (f3)
            3'd0:    begin e_mask = 4'(1 << off); e_wd = (wdata & 32'hFF)   << (8 * off); end
            3'd1:    begin e_mask = 4'(3 << off); e_wd = (wdata & 32'hFFFF) << (8 * off); end
            default: begin e_mask = 4'hF;         e_wd = wdata; end
         endcase
      end
      if (is_mem && ld) begin
         b = rdata >> (8 * off);
         case (f3)
            3'd0: begin v = b & 32'hFF;   if (v >= 128)   v = v - 256; end
            3'd4: v = b & 32'hFF;
            3'd1: begin v = b & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            3'd5: v = b & 32'hFFFF;
            default: v = rdata;
         endcase
         e_data = v;
      end
      if (is_mem && d >= TMO) begin e_err = 2; e_data = 0; end

      @(negedge clock);
      chk("accept_ready", in_ready, 1);
      in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
      in_addr = addr; in_wdata = wdata; in_rd = rd;
      mem_resp_valid = ($urandom % 4 == 0);
      @(negedge clock);
      in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
      mem_resp_valid = 0;
      if (is_mem) begin
         for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            mem_resp_valid = ($urandom % 2 == 1);
            mem_rdata = $urandom;
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("req_wen", mem_wen, st);
            chk("req_wmask", mem_wmask, e_mask);
            chk("req_wdata", mem_wdata, e_wd);
            chk("req_in_ready", in_ready, 0);
            @(negedge clock);
         end
         mem_req_ready = 0; mem_resp_valid = 0;
         chk("wait_req_valid", mem_req_valid, 0);
         for (int k = 0; k < TMO; k++) begin
            chk("wait_out_valid", out_valid, 0);
            if (k == d) begin mem_resp_valid = 1; mem_rdata = rdata; end
            @(negedge clock);
            mem_resp_valid = 0; mem_rdata = $urandom;
            if (k == d) break;
         end
      end else
         chk("nomem_req_valid", mem_req_valid, 0);
      for (int i = 0; i <= h; i++) begin
         out_ready = (i == h);
         mem_resp_valid = (is_mem && d >= TMO);
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, e_data);
         chk("out_rd", out_rd, rd);
         chk("out_err", out_err, e_err);
         chk("resp_in_ready", in_ready, 0);
         @(negedge clock);
      end
      out_ready = 0; mem_resp_valid = 0;
      chk("done_out_valid", out_valid, 0);
   endtask

   initial begin
      reset = 1; in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
      in_addr = 0; in_wdata = 0; in_rd = 0; mem_req_ready = 0; mem_resp_valid = 0;
      mem_rdata = 0; out_ready = 0;
      #12;
      chk_idle_outs("rst");
      @(negedge clock); reset = 0;

      // passthrough, LB/LBU, SH lane, misaligned LW, illegal funct3, both flags
      run_op(0, 0, 3'd0, 32'h1234_5678, 32'h0, 5'd7, 32'h0, 0, 0, 0);
      run_op(1, 0, 3'd0, 32'h8000_0003, 32'h0, 5'd1, 32'h80FF_0011, 0, 0, 0);
      run_op(1, 0, 3'd4, 32'h8000_0003, 32'h0, 5'd2, 32'h80FF_0011, 0, 1, 0);
      run_op(0, 1, 3'd1, 32'h8000_0002, 32'hAAAA_BEEF, 5'd3, 32'h0, 0, 0, 0);
      run_op(1, 0, 3'd2, 32'h8000_0001, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_op(1, 0, 3'd3, 32'h8000_0000, 32'h0, 5'd5, 32'h0, 0, 0, 0);
      run_op(1, 1, 3'd2, 32'h8000_0000, 32'h0, 5'd6, 32'h0, 0, 0, 0);
      // timeout, then a late response in IDLE, then a normal op
      run_op(1, 0, 3'd2, 32'h8000_0010, 32'h0, 5'd8, 32'h0, 0, 99, 0);
      @(negedge clock); mem_resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clock); mem_resp_valid = 0;
      chk("late_resp_out_valid", out_valid, 0);
      chk("late_resp_in_ready", in_ready, 1);
      run_op(1, 0, 3'd5, 32'h8000_0012, 32'h0, 5'd9, 32'h1234_ABCD, 0, 0, 0);
      // response on the last WAIT cycle beats the timeout
      run_op(1, 0, 3'd1, 32'h8000_0002, 32'h0, 5'd10, 32'h8001_0000, 0, TMO - 1, 0);
      // request and output backpressure
      run_op(0, 1, 3'd0, 32'h8000_0021, 32'h0000_00A5, 5'd11, 32'h0, 5, 2, 3);

      // reset while waiting for a response
      @(negedge clock);
      in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'd2;
      in_addr = 32'h8000_0040; in_rd = 5'd12;
      @(negedge clock); in_valid = 0; mem_req_ready = 1;
      @(negedge clock); mem_req_ready = 0;
      chk("wait_req_valid_pre_rst", mem_req_valid, 0);
      #2 reset = 1;
      #1 chk_idle_outs("rst_wait");
      @(negedge clock); reset = 0;
      @(negedge clock);
      chk("post_rst_req_valid", mem_req_valid, 0);
      run_op(1, 0, 3'd2, 32'h8000_0044, 32'h0, 5'd13, 32'hCAFE_F00D, 0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         int r;
         bit ld, st;
         r  = int'($urandom % 8);
         ld = (r inside {1, 2, 3, 7});
         st = (r inside {4, 5, 6, 7});
         run_op(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
                int'($urandom % 3), int'($urandom % (TMO + 2)), int'($urandom % 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
